// File: rtl/hawk_comp_wr_mngr.sv
`default_nettype none
// ============================================================================
// Module   : hawk_comp_wr_mngr
// Purpose  : Streams one compressed page from the compressor FIFO to memory as
//            single-beat AXI4 writes, one outstanding write at a time.
//            Optional HAWK_CWR_ZERO_PAD_EN zeroes the unused tail of the last beat.
// Revision : 1.0 - initial release
// ============================================================================
module hawk_comp_wr_mngr (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         comp_trigger,
  input  logic [63:0]  comp_cPage_byteStart,
  input  logic [13:0]  comp_size,
  input  logic         wrfifo_empty,
  input  logic [511:0] wrfifo_rdata,
  output logic         wrfifo_pop,
  output logic         wrfifo_reset,
  output logic         awvalid,
  input  logic         awready,
  output logic [63:0]  awaddr,
  output logic [7:0]   awlen,
  output logic         wvalid,
  input  logic         wready,
  output logic [511:0] wdata,
  output logic         wlast,
  input  logic         bvalid,
  output logic         bready,
  input  logic [1:0]   bresp,
  output logic         comp_mngr_done,
  output logic         comp_mngr_err
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RESET_FIFO = 3'd1,
    WAIT_DATA  = 3'd2,
    ADDR_DATA  = 3'd3,
    WAIT_RESP  = 3'd4,
    DONE       = 3'd5,
    CFG_ERROR  = 3'd6,
    BUS_ERROR  = 3'd7
  } state_t;

  state_t       r_state;
  logic [63:0]  r_base;
  logic [5:0]   r_tail;
  logic [6:0]   r_cnt;
  logic [6:0]   r_idx;

  logic         w_size_legal;
  logic [6:0]   w_beats;
  logic         w_last_beat;
  logic [63:0]  w_beat_addr;
  logic [511:0] w_beat_data;
  logic         w_aw_ok;
  logic         w_w_ok;

  assign w_size_legal = (comp_size != 14'd0) && (comp_size < 14'd4096);
  assign w_beats      = comp_size[12:6] + 7'd1;
  assign w_last_beat  = (r_cnt == 7'd1);
  assign w_beat_addr  = r_base + {51'd0, r_idx, 6'd0};
  // A channel counts as finished once its valid has dropped or is handshaking now
  assign w_aw_ok      = !awvalid || awready;
  assign w_w_ok       = !wvalid || wready;

`ifdef HAWK_CWR_ZERO_PAD_EN
  always_comb begin
    w_beat_data = wrfifo_rdata;
    if (w_last_beat) begin
      for (int b = 0; b < 64; b++) begin
        if (b >= int'(r_tail)) w_beat_data[8*b +: 8] = 8'h00;
      end
    end
  end
`else
  assign w_beat_data = wrfifo_rdata;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= IDLE;
      r_base         <= 64'd0;
      r_tail         <= 6'd0;
      r_cnt          <= 7'd0;
      r_idx          <= 7'd0;
      wrfifo_pop     <= 1'b0;
      wrfifo_reset   <= 1'b0;
      awvalid        <= 1'b0;
      awaddr         <= 64'd0;
      awlen          <= 8'd0;
      wvalid         <= 1'b0;
      wdata          <= 512'd0;
      wlast          <= 1'b0;
      bready         <= 1'b0;
      comp_mngr_done <= 1'b0;
      comp_mngr_err  <= 1'b0;
    end else begin
      wrfifo_pop     <= 1'b0;
      wrfifo_reset   <= 1'b0;
      comp_mngr_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (comp_trigger && !comp_mngr_done) begin
            r_base <= comp_cPage_byteStart;
            r_tail <= comp_size[5:0];
            r_cnt  <= w_beats;
            r_idx  <= 7'd0;
            if (w_size_legal) begin
              wrfifo_reset <= 1'b1;
              r_state      <= RESET_FIFO;
            end else begin
              comp_mngr_err <= 1'b1;
              r_state       <= CFG_ERROR;
            end
          end
        end
        RESET_FIFO: r_state <= WAIT_DATA;
        WAIT_DATA: begin
          if (!wrfifo_empty) begin
            wdata      <= w_beat_data;
            wrfifo_pop <= 1'b1;
            awaddr     <= w_beat_addr;
            awlen      <= 8'd0;
            wlast      <= 1'b1;
            awvalid    <= 1'b1;
            wvalid     <= 1'b1;
            r_state    <= ADDR_DATA;
          end
        end
        ADDR_DATA: begin
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if (w_aw_ok && w_w_ok) begin
            bready  <= 1'b1;
            r_state <= WAIT_RESP;
          end
        end
        WAIT_RESP: begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp == 2'b00) begin
              r_cnt   <= r_cnt - 7'd1;
              r_idx   <= r_idx + 7'd1;
              r_state <= w_last_beat ? DONE : WAIT_DATA;
            end else begin
              comp_mngr_err <= 1'b1;
              r_state       <= BUS_ERROR;
            end
          end
        end
        DONE: begin
          comp_mngr_done <= 1'b1;
          r_state        <= IDLE;
        end
        default: begin
          awvalid       <= 1'b0;
          wvalid        <= 1'b0;
          bready        <= 1'b0;
          comp_mngr_err <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hawk_comp_wr_mngr.sv
`default_nettype none
// tb_hawk_comp_wr_mngr: randomized FIFO/AXI slave environment with a queue-based
// page model; every write is compared against the expected address/data list.
module tb_hawk_comp_wr_mngr;

`ifdef HAWK_CWR_ZERO_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         comp_trigger;
  logic [63:0]  comp_cPage_byteStart;
  logic [13:0]  comp_size;
  logic         wrfifo_empty;
  logic [511:0] wrfifo_rdata;
  logic         wrfifo_pop, wrfifo_reset;
  logic         awvalid, awready;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic         wvalid, wready, wlast;
  logic [511:0] wdata;
  logic         bvalid, bready;
  logic [1:0]   bresp;
  logic         comp_mngr_done, comp_mngr_err;

  always #5 clk_i = ~clk_i;

  hawk_comp_wr_mngr dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .comp_trigger(comp_trigger),
    .comp_cPage_byteStart(comp_cPage_byteStart), .comp_size(comp_size),
    .wrfifo_empty(wrfifo_empty), .wrfifo_rdata(wrfifo_rdata),
    .wrfifo_pop(wrfifo_pop), .wrfifo_reset(wrfifo_reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .comp_mngr_done(comp_mngr_done), .comp_mngr_err(comp_mngr_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Environment state
  logic [511:0] fifo_q[$];
  logic [511:0] src_q[$];
  logic [511:0] exp_words[$];
  logic [63:0]  log_addr[$];
  logic [511:0] log_data[$];
  bit  feed_en = 0, fast = 0;
  int  aw_delay = 0, aw_wait = 0, bus_err_beat = -1, b_count = 0;
  int  pop_cnt = 0, pop_empty = 0, done_cnt = 0, frst_cnt = 0, aw_valid_cycles = 0;
  int  viol_out = 0, viol_stab = 0, awlen_bad = 0, wlast_bad = 0;
  bit  pend_aw = 0, pend_w = 0, b_fire = 0, prev_aw_hold = 0, prev_w_hold = 0;
  logic [63:0]  prev_awaddr;
  logic [511:0] prev_wdata;

  // Expected beat content for a page of the given size
  function automatic logic [511:0] exp_beat(input logic [511:0] w, input int size, input bit last);
    logic [511:0] r = w;
    if (PAD && last) for (int b = size % 64; b < 64; b++) r[8*b +: 8] = 8'h00;
    return r;
  endfunction

  // FIFO model and AXI slave, all acting on the falling edge
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      fifo_q.delete();
      awready = 0; wready = 0; bvalid = 0; bresp = 2'd0;
      pend_aw = 0; pend_w = 0; b_fire = 0; prev_aw_hold = 0; prev_w_hold = 0; aw_wait = 0;
    end else begin
      if (comp_mngr_done) done_cnt++;
      if (awvalid) aw_valid_cycles++;
      if (wrfifo_reset) begin
        fifo_q.delete(); feed_en = 1; frst_cnt++;
      end else begin
        if (wrfifo_pop) begin
          pop_cnt++;
          if (fifo_q.size() == 0) pop_empty++; else void'(fifo_q.pop_front());
        end
        if (feed_en && src_q.size() > 0 && (fast || $urandom_range(0, 3) != 0))
          fifo_q.push_back(src_q.pop_front());
      end
      if (b_fire) bvalid = 0;
      if (pend_aw && pend_w && !bvalid && (fast || $urandom_range(0, 2) != 0)) begin
        bvalid = 1;
        bresp  = (b_count == bus_err_beat) ? 2'd2 : 2'd0;
        b_count++;
        pend_aw = 0; pend_w = 0;
      end
      if (prev_aw_hold && (!awvalid || awaddr !== prev_awaddr)) viol_stab++;
      if (prev_w_hold && (!wvalid || wdata !== prev_wdata)) viol_stab++;
      if (aw_delay > 0) begin
        if (awvalid && aw_wait >= aw_delay) awready = 1;
        else begin awready = 0; if (awvalid) aw_wait++; else aw_wait = 0; end
      end else awready = fast ? 1'b1 : 1'($urandom_range(0, 1));
      wready = fast ? 1'b1 : 1'($urandom_range(0, 1));
      if (awvalid && awready) begin
        if (pend_aw || bvalid) viol_out++;
        if (awlen != 8'd0) awlen_bad++;
        log_addr.push_back(awaddr);
        pend_aw = 1;
      end
      if (wvalid && wready) begin
        if (pend_w || bvalid) viol_out++;
        if (!wlast) wlast_bad++;
        log_data.push_back(wdata);
        pend_w = 1;
      end
      prev_aw_hold = awvalid && !awready; prev_awaddr = awaddr;
      prev_w_hold  = wvalid && !wready;   prev_wdata  = wdata;
      b_fire = bvalid && bready;
    end
    wrfifo_empty = (fifo_q.size() == 0);
    wrfifo_rdata = (fifo_q.size() == 0) ? 512'd0 : fifo_q[0];
  end

  task automatic do_reset();
    rst_ni = 0; comp_trigger = 0;
    repeat (3) @(negedge clk_i);
    rst_ni = 1;
    @(negedge clk_i);
  endtask

  task automatic clear_env(input int size);
    logic [511:0] w;
    src_q.delete(); exp_words.delete(); log_addr.delete(); log_data.delete();
    pop_cnt = 0; pop_empty = 0; done_cnt = 0; frst_cnt = 0; aw_valid_cycles = 0;
    viol_out = 0; viol_stab = 0; awlen_bad = 0; wlast_bad = 0; b_count = 0; feed_en = 0;
    for (int i = 0; i < size / 64 + 1; i++) begin
      for (int k = 0; k < 16; k++) w[32*k +: 32] = $urandom();
      src_q.push_back(w); exp_words.push_back(w);
    end
  endtask

  task automatic trigger(input logic [63:0] base, input int size);
    @(negedge clk_i);
    comp_cPage_byteStart = base; comp_size = size[13:0]; comp_trigger = 1;
    @(negedge clk_i);
    comp_trigger = 0;
  endtask

  task automatic run_page(input string tag, input logic [63:0] base, input int size, input int trig_mid);
    int n = size / 64 + 1;
    int cyc = 0;
    clear_env(size);
    trigger(base, size);
    while (done_cnt == 0 && !comp_mngr_err && cyc < 6000) begin
      @(negedge clk_i);
      cyc++;
      if (trig_mid != 0 && cyc == trig_mid) begin
        comp_size = 14'd5; comp_cPage_byteStart = 64'hDEAD_0000; comp_trigger = 1;
      end else comp_trigger = 0;
    end
    repeat (4) @(negedge clk_i);
    chk({tag, "_in_time"}, (cyc < 6000), 1);
    chk({tag, "_beats"}, log_addr.size(), n);
    chk({tag, "_wbeats"}, log_data.size(), n);
    for (int i = 0; i < n && i < log_addr.size() && i < log_data.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), log_addr[i], base + 64'(i) * 64);
      chk($sformatf("%s_data%0d", tag, i), log_data[i], exp_beat(exp_words[i], size, i == n - 1));
    end
    chk({tag, "_pops"}, pop_cnt, n);
    chk({tag, "_pop_empty"}, pop_empty, 0);
    chk({tag, "_done"}, done_cnt, 1);
    chk({tag, "_err"}, comp_mngr_err, 0);
    chk({tag, "_fiforst"}, frst_cnt, 1);
    chk({tag, "_outstanding"}, viol_out, 0);
    chk({tag, "_stable"}, viol_stab, 0);
    chk({tag, "_awlen_wlast"}, awlen_bad + wlast_bad, 0);
  endtask

  task automatic cfg_err(input string tag, input int size);
    clear_env(0);
    trigger(64'h1000, size);
    repeat (8) @(negedge clk_i);
    chk({tag, "_err"}, comp_mngr_err, 1);
    chk({tag, "_no_aw"}, aw_valid_cycles, 0);
    chk({tag, "_no_fiforst"}, frst_cnt, 0);
    chk({tag, "_no_done"}, done_cnt, 0);
    do_reset();
  endtask

  initial begin
    logic [63:0] b;
    int sz, cyc;
    logic [511:0] e;
    rst_ni = 0; comp_trigger = 0; comp_cPage_byteStart = 64'd0; comp_size = 14'd0;
    repeat (3) @(negedge clk_i);
    chk("rst_ctrl", {awvalid, wvalid, bready, wrfifo_pop, wrfifo_reset, comp_mngr_done, comp_mngr_err}, 0);
    chk("rst_awaddr", awaddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_awlen_wlast", {awlen, wlast}, 0);
    rst_ni = 1;
    @(negedge clk_i);

    fast = 1;
    run_page("req035", 64'h1000, 100, 0);
    run_page("req036", 64'h1000, 4095, 0);
    aw_delay = 5;
    run_page("awdelay", 64'h3000, 10, 0);
    run_page("awdelay2", 64'h4000, 200, 0);
    aw_delay = 0;

    cfg_err("size0", 0);
    cfg_err("size4096", 4096);

    // Slave error response on the second beat
    clear_env(300);
    bus_err_beat = 1;
    trigger(64'h5000, 300);
    cyc = 0;
    while (!comp_mngr_err && cyc < 2000) begin @(negedge clk_i); cyc++; end
    repeat (20) @(negedge clk_i);
    chk("buserr_in_time", (cyc < 2000), 1);
    chk("buserr_err", comp_mngr_err, 1);
    chk("buserr_no_done", done_cnt, 0);
    chk("buserr_aw_count", log_addr.size(), 2);
    chk("buserr_valids", {awvalid, wvalid}, 0);
    bus_err_beat = -1;
    do_reset();

    fast = 0;
    for (int p = 0; p < 12; p++) begin
      b = {$urandom(), $urandom()};
      b[5:0] = 6'd0;
      sz = (p % 3 == 0) ? $urandom_range(700, 1500) : $urandom_range(1, 700);
      run_page($sformatf("rnd%0d", p), b, sz, (p % 3 == 0) ? 8 : 0);
    end
    run_page("edge64", 64'h8000, 64, 0);
    run_page("edge1", 64'h9000, 1, 0);

    run_page("pad70", 64'h2000, 70, 0);
    if (log_data.size() >= 2) begin
      e = exp_words[1];
      if (PAD) e[511:48] = '0;
      chk("pad70_beat2", log_data[1], e);
    end

    // Reset in the middle of a page
    clear_env(1000);
    trigger(64'hA000, 1000);
    cyc = 0;
    while (log_addr.size() < 3 && cyc < 2000) begin @(negedge clk_i); cyc++; end
    chk("midrst_progress", (cyc < 2000), 1);
    rst_ni = 0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
    done_cnt = 0;
    repeat (30) @(negedge clk_i);
    chk("midrst_no_done", done_cnt, 0);
    chk("midrst_idle", {awvalid, wvalid, comp_mngr_err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hawk_comp_wr_mngr.md
HAWK_COMP_WR_MNGR -- requirements
Module: hawk_comp_wr_mngr

Interface
REQ-001 SHALL have clk_i, input, 1, clock; all state updates on posedge clk_i.
REQ-002 SHALL have rst_ni, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have comp_trigger, input, 1, start request for one compressed-page write.
REQ-004 SHALL have comp_cPage_byteStart, input, 64, destination byte address, 64B-aligned.
REQ-005 SHALL have comp_size, input, 14, compressed page size in bytes; legal range 1..4095.
REQ-006 SHALL have wrfifo_empty / wrfifo_rdata / wrfifo_pop: input 1 / input 512 / output 1; compressor output FIFO, first-word-fall-through.
REQ-007 SHALL have wrfifo_reset, output, 1, one-cycle pointer reset to the compressor write FIFO.
REQ-008 SHALL have awvalid / awready / awaddr / awlen: output 1 / input 1 / output 64 / output 8; AXI4 write address channel.
REQ-009 SHALL have wvalid / wready / wdata / wlast: output 1 / input 1 / output 512 / output 1; AXI4 write data channel.
REQ-010 SHALL have bvalid / bready / bresp: input 1 / output 1 / input 2; AXI4 write response channel.
REQ-011 SHALL have comp_mngr_done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have comp_mngr_err, output, 1, sticky error flag.

Function
REQ-013 SHALL implement states IDLE, RESET_FIFO, WAIT_DATA, ADDR_DATA, WAIT_RESP, DONE, CFG_ERROR, BUS_ERROR.
REQ-014 IDLE: on comp_trigger=1 and comp_mngr_done=0, SHALL capture address and size and go to RESET_FIFO if size is legal, else CFG_ERROR.
REQ-015 Capture SHALL compute beat count = (comp_size>>6)+1 in a 7-bit counter; maximum value is 64.
REQ-016 RESET_FIFO SHALL assert wrfifo_reset for exactly one cycle, then go to WAIT_DATA.
REQ-017 WAIT_DATA SHALL wait for wrfifo_empty=0, then load wdata from wrfifo_rdata, assert wrfifo_pop for one cycle, and go to ADDR_DATA.
REQ-018 ADDR_DATA SHALL drive awvalid and wvalid with awlen=0 and wlast=1, so that each beat is a single-beat transaction.
REQ-019 ADDR_DATA: AW and W handshakes SHALL complete independently; each valid deasserts the cycle after its own handshake, and the state advances to WAIT_RESP only when both are complete.
REQ-020 awaddr SHALL equal base address + 64*beat index; beat index 0 uses the captured base address.
REQ-021 WAIT_RESP SHALL hold bready=1; on bvalid with bresp=0 it decrements the counter and goes to DONE if the counter reaches 0, else WAIT_DATA.
REQ-022 WAIT_RESP on bvalid with bresp!=0 SHALL go to BUS_ERROR.
REQ-023 DONE SHALL pulse comp_mngr_done for one cycle and return to IDLE.
REQ-024 CFG_ERROR and BUS_ERROR SHALL be terminal until reset, with comp_mngr_err=1 and all valids at 0.
REQ-025 SHALL never hold more than one outstanding write.
REQ-026 awvalid and wvalid, once asserted, SHALL hold with stable payload until the handshake.
REQ-027 A comp_trigger asserted outside IDLE SHALL be ignored.
REQ-028 A beat from an empty FIFO SHALL never be popped or written.

Reset
REQ-029 Reset SHALL force state IDLE and counter 0.
REQ-030 Reset SHALL force awvalid, wvalid, bready, wrfifo_pop, wrfifo_reset, comp_mngr_done and comp_mngr_err to 0.
REQ-031 Reset SHALL force awaddr and wdata to 0, awlen to 0 and wlast to 0.
REQ-032 Reset mid-transaction SHALL abandon the page; no done pulse follows.

Configuration
REQ-033 With HAWK_CWR_ZERO_PAD_EN defined, the final beat SHALL zero wdata bytes at byte offsets >= (comp_size mod 64); a final offset of 0 yields an all-zero beat.
REQ-034 Without HAWK_CWR_ZERO_PAD_EN, the final beat SHALL pass wrfifo_rdata unmodified.

Verification
REQ-035 Trigger with size=100 and base 0x1000, FIFO full, immediate ready/OKAY -> 2 writes at 0x1000 and 0x1040, each awlen=0 and wlast=1, two pops, and one done pulse.
REQ-036 Size=4095 -> 64 writes covering 0x1000..0x1FC0, then done.
REQ-037 Size=0 or size=4096 -> CFG_ERROR, err=1, no awvalid.
REQ-038 awready delayed 5 cycles while wready=1 -> W completes first and AW is held stable, one B is awaited, and no double write occurs.
REQ-039 bresp=2 on the second beat -> BUS_ERROR, err=1, no done pulse, no further AW.
REQ-040 Size=70 with HAWK_CWR_ZERO_PAD_EN defined -> on beat 2, bytes 6..63 are zero; without the macro, beat 2 equals the FIFO data.
